// File: rtl/centroid_overlay.sv
// Crosshair overlay on a raster RGB888 stream, positioned from frame-synchronous centroid results.
// The marker persists for HOLD_FRAMES frames after the last genuine detection.
module centroid_overlay #(
    parameter int          IMG_WIDTH      = 640,
    parameter int          IMG_HEIGHT     = 480,
    parameter int          CROSS_HALF_LEN = 10,
    parameter int          CROSS_HALF_TH  = 1,
    parameter int          HOLD_FRAMES    = 4,
    parameter logic [23:0] MARK_COLOR     = 24'h00FF00
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [9:0]  i_centroid_x,
    input  logic [8:0]  i_centroid_y,
    input  logic        i_centroid_valid,
    input  logic        i_object_valid,
    input  logic [23:0] i_pixel,
    input  logic        i_pixel_valid,
    output logic [23:0] o_pixel,
    output logic        o_pixel_valid,
    output logic        o_marker_on
);

    localparam int          MW       = $clog2(HOLD_FRAMES + 1);
    localparam logic [MW-1:0] MISS_SAT = MW'(HOLD_FRAMES);
    localparam logic [9:0]  X_LAST   = 10'(IMG_WIDTH - 1);
    localparam logic [8:0]  Y_LAST   = 9'(IMG_HEIGHT - 1);
    localparam logic [10:0] W11      = 11'(IMG_WIDTH);
    localparam logic [10:0] H11      = 11'(IMG_HEIGHT);
    localparam logic [10:0] LEN11    = 11'(CROSS_HALF_LEN);
    localparam logic [10:0] TH11     = 11'(CROSS_HALF_TH);

    logic [9:0]    x_cnt, pending_x, active_x, fresh_x, draw_ax;
    logic [8:0]    y_cnt, pending_y, active_y, fresh_y, draw_ay;
    logic          pending_fresh, marker_on;
    logic [MW-1:0] miss_cnt, miss_next;
    logic          frame_start, strobe_ok, fresh, on_next, draw_on, marker_px;
    logic [10:0]   xx, yy, ax, ay, dx, dy;

    // A strobe on the frame-start cycle takes priority over any pending result,
    // and the frame-start pixel is drawn with the state being applied on that edge.
    always_comb begin
        frame_start = i_pixel_valid && (x_cnt == 10'd0) && (y_cnt == 9'd0);
        strobe_ok   = i_centroid_valid && i_object_valid &&
                      ({1'b0, i_centroid_x} < W11) && ({2'b00, i_centroid_y} < H11);
        fresh       = strobe_ok || pending_fresh;
        fresh_x     = strobe_ok ? i_centroid_x : pending_x;
        fresh_y     = strobe_ok ? i_centroid_y : pending_y;
        if (fresh)
            miss_next = '0;
        else if (miss_cnt >= MISS_SAT)
            miss_next = MISS_SAT;
        else
            miss_next = miss_cnt + MW'(1);
        on_next = (miss_next < MISS_SAT);

        draw_ax = (frame_start && fresh) ? fresh_x : active_x;
        draw_ay = (frame_start && fresh) ? fresh_y : active_y;
        draw_on = frame_start ? on_next : marker_on;

        // Distances are taken larger-minus-smaller so arms clip instead of wrapping.
        xx = {1'b0, x_cnt};
        yy = {2'b00, y_cnt};
        ax = {1'b0, draw_ax};
        ay = {2'b00, draw_ay};
        dx = (xx >= ax) ? (xx - ax) : (ax - xx);
        dy = (yy >= ay) ? (yy - ay) : (ay - yy);
        marker_px = draw_on && (((dx <= TH11) && (dy <= LEN11)) ||
                                ((dy <= TH11) && (dx <= LEN11)));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            x_cnt         <= '0;
            y_cnt         <= '0;
            pending_x     <= '0;
            pending_y     <= '0;
            pending_fresh <= 1'b0;
            active_x      <= '0;
            active_y      <= '0;
            miss_cnt      <= MISS_SAT;
            marker_on     <= 1'b0;
            o_pixel       <= '0;
            o_pixel_valid <= 1'b0;
        end else begin
            if (i_pixel_valid) begin
                if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= (y_cnt == Y_LAST) ? 9'd0 : y_cnt + 9'd1;
                end else begin
                    x_cnt <= x_cnt + 10'd1;
                end
            end

            if (i_centroid_valid) begin
                if (strobe_ok) begin
                    pending_x     <= i_centroid_x;
                    pending_y     <= i_centroid_y;
                    pending_fresh <= 1'b1;
                end else begin
                    pending_fresh <= 1'b0;
                end
            end

            if (frame_start) begin
                pending_fresh <= 1'b0;
                if (fresh) begin
                    active_x <= fresh_x;
                    active_y <= fresh_y;
                end
                miss_cnt  <= miss_next;
                marker_on <= on_next;
            end

            o_pixel_valid <= i_pixel_valid;
            if (i_pixel_valid)
                o_pixel <= marker_px ? MARK_COLOR : i_pixel;
        end
    end

    assign o_marker_on = marker_on;

endmodule

// File: tb/tb_centroid_overlay.sv
// Scoreboard bench for centroid_overlay on a reduced 64x32 image so that
// many frames fit in a short run.
module tb_centroid_overlay;

    localparam int          W     = 64;
    localparam int          H     = 32;
    localparam int          LEN   = 10;
    localparam int          TH    = 1;
    localparam int          HOLD  = 4;
    localparam logic [23:0] COLOR = 24'h00FF00;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic [9:0]  i_centroid_x = '0;
    logic [8:0]  i_centroid_y = '0;
    logic        i_centroid_valid = 1'b0;
    logic        i_object_valid = 1'b0;
    logic [23:0] i_pixel = '0;
    logic        i_pixel_valid = 1'b0;
    logic [23:0] o_pixel;
    logic        o_pixel_valid;
    logic        o_marker_on;

    centroid_overlay #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .CROSS_HALF_LEN(LEN),
        .CROSS_HALF_TH(TH), .HOLD_FRAMES(HOLD), .MARK_COLOR(COLOR)
    ) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_centroid_x(i_centroid_x), .i_centroid_y(i_centroid_y),
        .i_centroid_valid(i_centroid_valid), .i_object_valid(i_object_valid),
        .i_pixel(i_pixel), .i_pixel_valid(i_pixel_valid),
        .o_pixel(o_pixel), .o_pixel_valid(o_pixel_valid), .o_marker_on(o_marker_on)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [23:0] px;
        logic        on;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    int  mx, my, pxq, pyq, ax_m, ay_m, miss_m;
    bit  pfresh_m, on_m;

    logic        exp_valid = 1'b0;
    logic        rst_seen = 1'b1;
    logic [23:0] held_exp = '0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int absDiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic modelReset();
        mx = 0; my = 0; pxq = 0; pyq = 0; ax_m = 0; ay_m = 0;
        miss_m = HOLD; pfresh_m = 0; on_m = 0;
    endtask

    // One clock of stimulus; the model is advanced with the same inputs.
    task automatic applyStimulus(input bit pv, input bit cv, input bit obj, input int cx, input int cy);
        bit ok, fs, mk;
        exp_t e;
        @(negedge i_clk);
        i_pixel_valid    = pv;
        i_pixel          = 24'($urandom);
        i_centroid_valid = cv;
        i_object_valid   = obj;
        i_centroid_x     = 10'(cx);
        i_centroid_y     = 9'(cy);
        ok = cv && obj && (cx < W) && (cy < H);
        fs = pv && (mx == 0) && (my == 0);
        if (fs) begin
            if (ok) begin ax_m = cx; ay_m = cy; miss_m = 0; end
            else if (pfresh_m) begin ax_m = pxq; ay_m = pyq; miss_m = 0; end
            else if (miss_m < HOLD) miss_m++;
            on_m = (miss_m < HOLD);
        end
        if (pv) begin
            mk = on_m && ((absDiff(mx, ax_m) <= TH && absDiff(my, ay_m) <= LEN) ||
                          (absDiff(my, ay_m) <= TH && absDiff(mx, ax_m) <= LEN));
            e.px = mk ? COLOR : i_pixel;
            e.on = on_m;
            sb.push_back(e);
            if (mx == W - 1) begin mx = 0; my = (my == H - 1) ? 0 : my + 1; end
            else mx++;
        end
        if (cv) begin
            if (ok) begin pxq = cx; pyq = cy; pfresh_m = 1; end
            else pfresh_m = 0;
        end
        if (fs) pfresh_m = 0;
    endtask

    task automatic sendFrame(input int sidx, input int cx, input int cy, input bit obj);
        for (int idx = 0; idx < W * H; idx++) begin
            if (idx % 37 == 5) applyStimulus(0, 0, 0, 0, 0);
            applyStimulus(1, idx == sidx, obj, cx, cy);
        end
    endtask

    task automatic blank(input int n, input bit cv, input int cx, input int cy, input bit obj);
        for (int i = 0; i < n; i++) applyStimulus(0, cv && (i == 0), obj, cx, cy);
    endtask

    task automatic applyReset(input int n);
        @(negedge i_clk);
        i_rstn = 1'b0;
        i_pixel_valid = 1'b0;
        i_centroid_valid = 1'b0;
        modelReset();
        repeat (n) @(negedge i_clk);
        checkOutput("rst_valid", 32'(o_pixel_valid), 32'd0);
        checkOutput("rst_marker", 32'(o_marker_on), 32'd0);
        checkOutput("rst_pixel", 32'(o_pixel), 32'd0);
        i_rstn = 1'b1;
    endtask

    always @(posedge i_clk) begin
        rst_seen  <= !i_rstn;
        exp_valid <= i_rstn ? i_pixel_valid : 1'b0;
    end

    // Output monitor: pops one expected entry per valid output pixel.
    always @(negedge i_clk) begin
        exp_t e;
        if (rst_seen) held_exp = '0;
        checkOutput("pixel_valid", 32'(o_pixel_valid), 32'(exp_valid));
        if (o_pixel_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("pixel", 32'(o_pixel), 32'(e.px));
                checkOutput("marker_on", 32'(o_marker_on), 32'(e.on));
                held_exp = e.px;
            end
        end else begin
            checkOutput("pixel_hold", 32'(o_pixel), 32'(held_exp));
        end
    end

    initial begin
        modelReset();
        // T1: reset, two frames with no detection
        applyReset(3);
        sendFrame(-1, 0, 0, 0);
        sendFrame(-1, 0, 0, 0);
        checkOutput("t1_marker_off", 32'(o_marker_on), 32'd0);

        // T2: centred detection in blanking
        blank(20, 1, 32, 16, 1);
        sendFrame(-1, 0, 0, 0);
        checkOutput("t2_marker_on", 32'(o_marker_on), 32'd1);

        // T3: detection near the top-left corner, arms must clip
        blank(20, 1, 2, 1, 1);
        sendFrame(-1, 0, 0, 0);

        // T4: active at centre, mid-frame strobe only affects next frame
        blank(20, 1, 32, 16, 1);
        sendFrame(300, 10, 20, 1);
        sendFrame(-1, 0, 0, 0);

        // T5: persistence across explicit misses, then reacquire
        blank(20, 1, 20, 10, 1);
        sendFrame(-1, 0, 0, 0);
        checkOutput("t5_frame0_on", 32'(o_marker_on), 32'd1);
        for (int f = 1; f <= 5; f++) begin
            if (f == 2) blank(20, 1, 70, 10, 1);
            else        blank(20, 1, 20, 10, 0);
            sendFrame(-1, 0, 0, 0);
            checkOutput($sformatf("t5_frame%0d_on", f), 32'(o_marker_on), (f <= 3) ? 32'd1 : 32'd0);
        end
        blank(20, 1, 50, 20, 1);
        sendFrame(-1, 0, 0, 0);
        checkOutput("t5_reacquire_on", 32'(o_marker_on), 32'd1);

        // T6: strobe on the frame-start pixel, then reset mid-frame
        blank(20, 0, 0, 0, 0);
        sendFrame(0, 60, 30, 1);
        checkOutput("t6_coincident_on", 32'(o_marker_on), 32'd1);
        for (int i = 0; i < 100; i++) applyStimulus(1, 0, 0, 0, 0);
        applyReset(1);
        sendFrame(-1, 0, 0, 0);
        checkOutput("t6_post_reset_off", 32'(o_marker_on), 32'd0);
        blank(20, 1, 5, 5, 1);
        sendFrame(-1, 0, 0, 0);

        blank(5, 0, 0, 0, 0);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
